p_enc_scan_nxm: RTL and testbench

//  Parametrised, sequential priority encoder. Accepts an N-bit request vector

---
 rtl/p_enc_scan_nxm.sv | 147 ++++++++++++++
 tb/tb_p_enc_scan_nxm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/p_enc_scan_nxm.sv
// p_enc_scan_nxm
// Sequential priority encoder. A request vector D is taken over a valid/ready
// handshake. The index of every set bit is then emitted, one per output
// handshake, in priority order. The highest set bit goes first when
// MSB_FIRST=1, and the lowest set bit goes first otherwise. Each served bit is
// cleared as it is emitted. An all-zero vector produces a single beat with v=0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   D is valid
//   in_ready   block can accept a new vector
//   D          N-bit request vector
//   out_valid  Q/v/last/remaining are valid
//   out_ready  consumer accepts the current beat
//   Q          index of the current highest-priority pending bit
//   v          1 = Q is a real request, 0 = the accepted vector was all-zero
//   last       current beat is the final beat for this vector
//   remaining  set bits still pending, including the current beat

module p_enc_scan_nxm #(
    parameter  int N         = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int W         = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] D,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Q,
    output logic         v,
    output logic         last,
    output logic [W:0]   remaining
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        ZERO = 2'd2
    } state_t;

    state_t         state_q,     state_d;
    logic [N-1:0]   pending_q,   pending_d;
    logic [W:0]     remaining_q, remaining_d;

    logic [W-1:0]   scan_idx;
    logic [W:0]     d_count;
    logic           accept;
    logic           fire;

    // Priority pick over the pending bits. The loop lets the winning bit
    // overwrite any lower-priority match, so the scan direction sets the order.
    always_comb begin
        scan_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pending_q[i]) scan_idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pending_q[i]) scan_idx = W'(i);
            end
        end
    end

    // Population count of the incoming vector. It loads the beat counter on accept.
    always_comb begin
        d_count = '0;
        for (int i = 0; i < N; i++) begin
            d_count = d_count + (W+1)'(D[i]);
        end
    end

    // The outputs depend only on registered state. in_ready also opens on the
    // final beat, so that a new vector can load on the same edge without a
    // bubble. This is the only path from out_ready to in_ready.
    always_comb begin
        out_valid = (state_q != IDLE);
        v         = (state_q == SCAN);
        Q         = '0;
        last      = 1'b0;
        remaining = '0;
        if (state_q == SCAN) begin
            Q         = scan_idx;
            last      = (remaining_q == (W+1)'(1));
            remaining = remaining_q;
        end else if (state_q == ZERO) begin
            last      = 1'b1;
        end
        in_ready = (state_q == IDLE) | (out_valid & out_ready & last);
    end

    assign accept = in_valid & in_ready;
    assign fire   = out_valid & out_ready;

    // Next-state logic. An accept can only happen in IDLE or on the final
    // beat. In both cases the freshly sampled vector overrides the advance.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        remaining_d = remaining_q;

        case (state_q)
            IDLE: ;
            SCAN: begin
                if (fire) begin
                    pending_d   = pending_q & ~(N'(1) << scan_idx);
                    remaining_d = remaining_q - (W+1)'(1);
                    if (last) state_d = IDLE;
                end
            end
            ZERO: begin
                if (fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            if (D != '0) begin
                state_d     = SCAN;
                pending_d   = D;
                remaining_d = d_count;
            end else begin
                state_d     = ZERO;
                pending_d   = '0;
                remaining_d = '0;
            end
        end
    end

    // State registers. Reset discards any scan that is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_p_enc_scan_nxm.sv
// Testbench for p_enc_scan_nxm. It drives two instances, one with MSB_FIRST=1
// and one with MSB_FIRST=0, with identical stimulus. Each instance has its own
// scoreboard queue of expected beats.

module tb_p_enc_scan_nxm;

    localparam int N = 8;
    localparam int W = $clog2(N);

    typedef struct packed {
        logic [W-1:0] q;
        logic         v;
        logic         last;
        logic [W:0]   rem;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] D;
    logic         out_ready;

    logic         in_ready_m, out_valid_m, v_m, last_m;
    logic [W-1:0] q_m;
    logic [W:0]   rem_m;
    logic         in_ready_l, out_valid_l, v_l, last_l;
    logic [W-1:0] q_l;
    logic [W:0]   rem_l;

    beat_t exp_m[$];
    beat_t exp_l[$];

    int tests_run = 0;
    int tests_failed = 0;

    p_enc_scan_nxm #(.N(N), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
        .D(D), .out_valid(out_valid_m), .out_ready(out_ready), .Q(q_m),
        .v(v_m), .last(last_m), .remaining(rem_m)
    );

    p_enc_scan_nxm #(.N(N), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
        .D(D), .out_valid(out_valid_l), .out_ready(out_ready), .Q(q_l),
        .v(v_l), .last(last_l), .remaining(rem_l)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: the beat sequence for vector d in the chosen order.
    task automatic pushExpected(input logic [N-1:0] d);
        int cnt;
        int rem;
        cnt = 0;
        for (int i = 0; i < N; i++) if (d[i]) cnt++;
        if (cnt == 0) begin
            exp_m.push_back('{q: '0, v: 1'b0, last: 1'b1, rem: '0});
            exp_l.push_back('{q: '0, v: 1'b0, last: 1'b1, rem: '0});
        end else begin
            rem = cnt;
            for (int i = N - 1; i >= 0; i--) begin
                if (d[i]) begin
                    exp_m.push_back('{q: W'(i), v: 1'b1, last: (rem == 1), rem: (W+1)'(rem)});
                    rem--;
                end
            end
            rem = cnt;
            for (int i = 0; i < N; i++) begin
                if (d[i]) begin
                    exp_l.push_back('{q: W'(i), v: 1'b1, last: (rem == 1), rem: (W+1)'(rem)});
                    rem--;
                end
            end
        end
    endtask

    // Present d and wait for the handshake, then record the expected beats.
    // The task returns just after the accepting edge.
    task automatic applyStimulus(input logic [N-1:0] d, input bit hold);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        D = d;
        in_valid = 1'b1;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (in_ready_m) got = 1'b1;
        end
        checkOutput("accept_timeout", got, 1'b1);
        checkOutput("lsb_in_ready", in_ready_l, 1'b1);
        pushExpected(d);
        @(posedge clk); #1;
        if (!hold) begin
            in_valid = 1'b0;
            D = N'($urandom);
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (exp_m.size() == 0 && exp_l.size() == 0 && !out_valid_m && !out_valid_l) done = 1'b1;
        end
        checkOutput("drain_timeout", done, 1'b1);
    endtask

    // Scoreboard for the MSB-first instance. A held beat is compared against
    // the queue head and popped only on a handshake.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && out_valid_m) begin
            if (exp_m.size() == 0) begin
                checkOutput("msb_spurious_beat", out_valid_m, 1'b0);
            end else begin
                e = exp_m[0];
                checkOutput("msb_q", q_m, e.q);
                checkOutput("msb_v", v_m, e.v);
                checkOutput("msb_last", last_m, e.last);
                checkOutput("msb_remaining", rem_m, e.rem);
                if (out_ready) void'(exp_m.pop_front());
            end
        end
    end

    // Scoreboard for the LSB-first instance.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && out_valid_l) begin
            if (exp_l.size() == 0) begin
                checkOutput("lsb_spurious_beat", out_valid_l, 1'b0);
            end else begin
                e = exp_l[0];
                checkOutput("lsb_q", q_l, e.q);
                checkOutput("lsb_v", v_l, e.v);
                checkOutput("lsb_last", last_l, e.last);
                checkOutput("lsb_remaining", rem_l, e.rem);
                if (out_ready) void'(exp_l.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        D = '0;
        out_ready = 1'b1;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", out_valid_m, 1'b0);
        checkOutput("rst_q", q_m, '0);
        checkOutput("rst_v", v_m, 1'b0);
        checkOutput("rst_last", last_m, 1'b0);
        checkOutput("rst_remaining", rem_m, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", in_ready_m, 1'b1);

        // All-zero vector
        applyStimulus(8'h00, 1'b0);
        checkOutput("zero_out_valid", out_valid_m, 1'b1);
        drain();

        // Single bits
        for (int i = 0; i < N; i++) begin
            applyStimulus(N'(1) << i, 1'b0);
        end
        drain();

        // Four-bit pattern in both orders
        applyStimulus(8'b1010_0110, 1'b0);
        checkOutput("scan_in_ready_busy", in_ready_m, 1'b0);
        drain();

        // Backpressure: the beat holds for four cycles and D changes are ignored
        out_ready = 1'b0;
        applyStimulus(8'hC0, 1'b0);
        D = 8'hFF;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        checkOutput("bp_in_ready", in_ready_m, 1'b0);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Back-to-back vectors with in_valid held
        applyStimulus(8'h81, 1'b1);
        @(posedge clk); #1;
        D = 8'h10;
        @(negedge clk);
        checkOutput("b2b_q0_beat", q_m, 3'd0);
        checkOutput("b2b_q0_last", last_m, 1'b1);
        checkOutput("b2b_in_ready", in_ready_m, 1'b1);
        pushExpected(8'h10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_no_bubble", out_valid_m, 1'b1);
        checkOutput("b2b_q4", q_m, 3'd4);
        drain();

        // Reset pulsed during the first beat aborts the scan
        applyStimulus(8'h81, 1'b0);
        rst_n = 1'b0;
        exp_m.delete();
        exp_l.delete();
        @(negedge clk);
        checkOutput("mid_rst_out_valid", out_valid_m, 1'b0);
        checkOutput("mid_rst_q", q_m, '0);
        checkOutput("mid_rst_remaining", rem_m, '0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("mid_rst_no_beat", out_valid_m, 1'b0);
        end

        // The instance still works after the abort
        applyStimulus(8'h24, 1'b0);
        drain();
        checkOutput("msb_queue_left", exp_m.size(), 0);
        checkOutput("lsb_queue_left", exp_l.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
